// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/load-store request bundle and memory-side bus of mem_arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_adr;
  logic        if_rdy;
  logic [31:0] if_data;

  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_fun3;
  logic [31:0] ls_adr;
  logic [31:0] ls_wdata;
  logic        ls_rdy;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic [31:0] mem_adr;
  logic        mem_load;
  logic [3:0]  mem_be;
  logic [31:0] mem_in;
  logic [31:0] mem_out;

  logic        busy;

  modport slave (
    input  if_req, if_adr, ls_req, ls_we, ls_fun3, ls_adr, ls_wdata, mem_out,
    output if_rdy, if_data, ls_rdy, ls_rdata, ls_err,
           mem_adr, mem_load, mem_be, mem_in, busy
  );

  modport master (
    output if_req, if_adr, ls_req, ls_we, ls_fun3, ls_adr, ls_wdata, mem_out,
    input  if_rdy, if_data, ls_rdy, ls_rdata, ls_err,
           mem_adr, mem_load, mem_be, mem_in, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin share of one single-port memory between fetch and load/store
module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_IF_WAIT, S_LS_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_last_ls;
  logic [1:0]         r_lane;
  logic               r_we;
  logic [2:0]         r_fun3;

  logic               r_if_rdy;
  logic [31:0]        r_if_data;
  logic               r_ls_rdy;
  logic [31:0]        r_ls_rdata;
  logic               r_ls_err;
  logic [31:0]        r_mem_adr;
  logic               r_mem_load;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_in;

  logic               w_grant_ls;
  logic               w_grant_if;
  logic               w_ls_err;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_ld_data;
  logic               w_unused_if_lsb;

  // When both request, the side not granted last wins; r_last_ls=0 after reset lets LS win.
  assign w_grant_ls = bus.ls_req & (~bus.if_req | ~r_last_ls);
  assign w_grant_if = bus.if_req & ~w_grant_ls;
  assign w_unused_if_lsb = ^bus.if_adr[1:0];

  always_comb begin
    w_ls_err = 1'b1;
    case (bus.ls_fun3)
      3'b000:  w_ls_err = 1'b0;
      3'b001:  w_ls_err = bus.ls_adr[0];
      3'b010:  w_ls_err = |bus.ls_adr[1:0];
      3'b100:  w_ls_err = bus.ls_we;
      3'b101:  w_ls_err = bus.ls_we | bus.ls_adr[0];
      default: w_ls_err = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.ls_wdata;
    case (bus.ls_fun3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.ls_adr[1:0];
        w_wdata = {4{bus.ls_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = bus.ls_adr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.ls_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.ls_wdata;
      end
    endcase
  end

  assign w_byte = bus.mem_out[{r_lane, 3'b000} +: 8];
  assign w_half = r_lane[1] ? bus.mem_out[31:16] : bus.mem_out[15:0];

  always_comb begin
    w_ld_data = bus.mem_out;
    case (r_fun3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld_data = {24'h0, w_byte};
      3'b101:  w_ld_data = {16'h0, w_half};
      default: w_ld_data = bus.mem_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last_ls  <= 1'b0;
      r_lane     <= 2'b00;
      r_we       <= 1'b0;
      r_fun3     <= 3'b000;
      r_if_rdy   <= 1'b0;
      r_if_data  <= 32'h0;
      r_ls_rdy   <= 1'b0;
      r_ls_rdata <= 32'h0;
      r_ls_err   <= 1'b0;
      r_mem_adr  <= 32'h0;
      r_mem_load <= 1'b0;
      r_mem_be   <= 4'b0000;
      r_mem_in   <= 32'h0;
    end else begin
      // Response and write-strobe outputs are single-cycle pulses.
      r_if_rdy   <= 1'b0;
      r_if_data  <= 32'h0;
      r_ls_rdy   <= 1'b0;
      r_ls_rdata <= 32'h0;
      r_ls_err   <= 1'b0;
      r_mem_load <= 1'b0;
      r_mem_be   <= 4'b0000;
      r_mem_in   <= 32'h0;

      case (r_state)
        S_IDLE: begin
          if (w_grant_ls) begin
            r_last_ls <= 1'b1;
            r_lane    <= bus.ls_adr[1:0];
            r_we      <= bus.ls_we;
            r_fun3    <= bus.ls_fun3;
            if (w_ls_err) begin
              r_state  <= S_RESP;
              r_ls_rdy <= 1'b1;
              r_ls_err <= 1'b1;
            end else begin
              r_state   <= S_LS_WAIT;
              r_cnt     <= CNT_W'(MEM_LAT);
              r_mem_adr <= {bus.ls_adr[31:2], 2'b00};
              if (bus.ls_we) begin
                r_mem_load <= 1'b1;
                r_mem_be   <= w_be;
                r_mem_in   <= w_wdata;
              end
            end
          end else if (w_grant_if) begin
            r_last_ls <= 1'b0;
            r_state   <= S_IF_WAIT;
            r_cnt     <= CNT_W'(MEM_LAT);
            r_mem_adr <= {bus.if_adr[31:2], 2'b00};
          end
        end

        S_IF_WAIT, S_LS_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= S_RESP;
            r_mem_adr <= 32'h0;
            if (r_state == S_IF_WAIT) begin
              r_if_rdy  <= 1'b1;
              r_if_data <= bus.mem_out;
            end else begin
              r_ls_rdy   <= 1'b1;
              r_ls_rdata <= r_we ? 32'h0 : w_ld_data;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_RESP: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_rdy   = r_if_rdy;
  assign bus.if_data  = r_if_data;
  assign bus.ls_rdy   = r_ls_rdy;
  assign bus.ls_rdata = r_ls_rdata;
  assign bus.ls_err   = r_ls_err;
  assign bus.mem_adr  = r_mem_adr;
  assign bus.mem_load = r_mem_load;
  assign bus.mem_be   = r_mem_be;
  assign bus.mem_in   = r_mem_in;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a byte-level memory model
module tb_mem_arbiter;
  localparam int LAT = 2;
  localparam int P   = LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_LAT(LAT), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory array seen by the DUT: one registered address stage gives LAT=2.
  logic [31:0] env_mem [0:63];
  logic [31:0] adr_d = 32'h0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    adr_d <= bus.mem_adr;
    if (pl_en)
      env_mem[pl_idx] <= pl_data;
    else if (bus.mem_load)
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) env_mem[bus.mem_adr[7:2]][8*i +: 8] <= bus.mem_in[8*i +: 8];
  end
  assign bus.mem_out = env_mem[adr_d[7:2]];

  // Reference model: byte-addressed image plus the side granted most recently.
  logic [7:0] ref_b [0:255];
  bit         last_ls = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit is_err(input bit we, input logic [2:0] f, input logic [31:0] a);
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
    if (we && f[2]) return 1'b1;
    return (int'(a[7:0]) % sz(f)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = sz(f);
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[(int'(a[7:0]) + i) % 256]) << (8*i));
    if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < 4; i++) v = v | (32'(ref_b[int'({a[7:2], 2'b00}) + i]) << (8*i));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < sz(f); i++) ref_b[(int'(a[7:0]) + i) % 256] = 8'(wd >> (8*i));
  endtask

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
    logic [3:0] b;
    b = 4'b0000;
    for (int i = 0; i < sz(f); i++) b[int'(a[1:0]) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] exp_min(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] m;
    m = 32'h0;
    for (int j = 0; j < 4; j++) m[8*j +: 8] = 8'(wd >> (8*(j % sz(f))));
    return m;
  endfunction

  task automatic preload(input int idx, input logic [31:0] w);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 6'(idx); pl_data = w;
    @(posedge clk);
    #1 pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[(idx % 64) * 4 + i] = w[8*i +: 8];
  endtask

  task automatic do_round(input bit want_if, input bit want_ls, input logic [31:0] ia,
                          input bit we, input logic [2:0] f, input logic [31:0] la,
                          input logic [31:0] wd, output logic [31:0] got_ls);
    bit err, ls_first, two;
    int lat_ls, g_if, g_ls, r_if, r_ls, gap, pending, n_load, cyc;
    logic [1:0] exp_rdy;
    err      = want_ls && is_err(we, f, la);
    lat_ls   = err ? 0 : LAT;
    ls_first = want_ls && (!want_if || !last_ls);
    two      = want_if && want_ls;
    if (ls_first) begin
      g_ls = 0; r_ls = lat_ls + 1; g_if = r_ls + 1; r_if = g_if + LAT + 1;
    end else begin
      g_if = 0; r_if = LAT + 1; g_ls = r_if + 1; r_ls = g_ls + lat_ls + 1;
    end
    gap     = two ? (ls_first ? g_if : g_ls) : -1;
    pending = int'(want_if) + int'(want_ls);
    n_load  = 0;
    cyc     = 0;
    got_ls  = 32'h0;
    @(negedge clk);
    bus.if_adr = ia; bus.ls_we = we; bus.ls_fun3 = f; bus.ls_adr = la; bus.ls_wdata = wd;
    bus.if_req = want_if; bus.ls_req = want_ls;
    while (pending > 0 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (bus.mem_load) begin
        n_load++;
        check("store_cycle", 32'(cyc), 32'(g_ls + 1));
        check("mem_adr", bus.mem_adr, {la[31:2], 2'b00});
        check("mem_be", 32'(bus.mem_be), 32'(exp_be(f, la)));
        check("mem_in", bus.mem_in, exp_min(f, wd));
      end
      exp_rdy = {want_if && cyc == r_if, want_ls && cyc == r_ls};
      check("rdy_pattern", 32'({bus.if_rdy, bus.ls_rdy}), 32'(exp_rdy));
      check("busy", 32'(bus.busy), 32'(cyc != gap));
      if (exp_rdy == 2'b00)
        check("quiet_data", bus.if_data | bus.ls_rdata | 32'(bus.ls_err), 32'h0);
      if (exp_rdy[0]) begin
        check("ls_err", 32'(bus.ls_err), 32'(err));
        check("ls_rdata", bus.ls_rdata, (err || we) ? 32'h0 : ref_load(f, la));
        got_ls = bus.ls_rdata;
        if (!err && we) ref_store(f, la, wd);
        last_ls = 1'b1;
        bus.ls_req = 1'b0;
        pending--;
      end
      if (exp_rdy[1]) begin
        check("if_data", bus.if_data, ref_fetch(ia));
        last_ls = 1'b0;
        bus.if_req = 1'b0;
        pending--;
      end
    end
    check("load_count", 32'(n_load), 32'(want_ls && we && !err));
    @(posedge clk); @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'h0);
    check("idle_rdy", 32'({bus.if_rdy, bus.ls_rdy}), 32'h0);
  endtask

  logic [31:0] got;

  initial begin
    bus.if_req = 1'b0; bus.if_adr = 32'h0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_fun3 = 3'b000;
    bus.ls_adr = 32'h0; bus.ls_wdata = 32'h0;

    for (int i = 0; i < 64; i++) preload(i, $urandom());
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_rdy", 32'({bus.if_rdy, bus.ls_rdy, bus.ls_err}), 32'h0);
    check("rst_mem", bus.mem_adr | bus.mem_in | 32'({bus.mem_load, bus.mem_be}), 32'h0);
    check("rst_data", bus.if_data | bus.ls_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single fetch: address, busy and response timing cycle by cycle.
    preload(1, 32'h0000_0013);
    @(negedge clk);
    bus.if_adr = 32'h6; bus.if_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); @(negedge clk);
      check("t1_busy", 32'(bus.busy), 32'h1);
      check("t1_mem_adr", bus.mem_adr, (c < 3) ? 32'h4 : 32'h0);
      check("t1_if_rdy", 32'(bus.if_rdy), (c == 3) ? 32'h1 : 32'h0);
      check("t1_if_data", bus.if_data, (c == 3) ? 32'h13 : 32'h0);
    end
    bus.if_req = 1'b0;
    last_ls = 1'b0;
    @(posedge clk); @(negedge clk);
    check("t1_idle", 32'(bus.busy), 32'h0);

    // Load extension, halfword store, and error responses.
    preload(0, 32'h80FF_1234);
    do_round(1'b0, 1'b1, 32'h0, 1'b0, 3'b000, 32'h103, 32'h0, got);
    check("lb_const", got, 32'hFFFF_FF80);
    do_round(1'b0, 1'b1, 32'h0, 1'b0, 3'b100, 32'h103, 32'h0, got);
    check("lbu_const", got, 32'h0000_0080);
    do_round(1'b0, 1'b1, 32'h0, 1'b0, 3'b101, 32'h102, 32'h0, got);
    check("lhu_const", got, 32'h0000_80FF);
    do_round(1'b0, 1'b1, 32'h0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, got);
    do_round(1'b0, 1'b1, 32'h0, 1'b1, 3'b010, 32'h301, 32'h5555_5555, got);
    do_round(1'b0, 1'b1, 32'h0, 1'b0, 3'b011, 32'h300, 32'h0, got);

    for (int k = 0; k < 150; k++) begin
      int mode;
      logic [31:0] ia, la, wd;
      logic [2:0] f;
      bit we;
      mode = int'($urandom_range(1, 3));
      ia = $urandom(); la = $urandom(); wd = $urandom();
      f  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) la[1:0] = la[1:0] & ~2'(sz(f) - 1);
      do_round(mode[0], mode[1], ia, we, f, la, wd, got);
    end

    // Reset during the second wait cycle of a store aborts it silently.
    @(negedge clk);
    bus.ls_we = 1'b1; bus.ls_fun3 = 3'b000; bus.ls_adr = 32'h41; bus.ls_wdata = 32'hA5;
    bus.ls_req = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_strobe", 32'(bus.mem_load), 32'h1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_mem_adr", bus.mem_adr, 32'h0);
    check("abort_rdy", 32'({bus.if_rdy, bus.ls_rdy, bus.ls_err, bus.mem_load}), 32'h0);
    check("abort_data", bus.if_data | bus.ls_rdata | bus.mem_in, 32'h0);
    ref_store(3'b000, 32'h41, 32'hA5);
    last_ls = 1'b0;
    bus.ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_rdy", 32'({bus.if_rdy, bus.ls_rdy}), 32'h0);
    end

    // Both requests held continuously: LS, IF, LS, IF every P cycles.
    @(negedge clk);
    bus.if_adr = 32'h48; bus.ls_we = 1'b0; bus.ls_fun3 = 3'b010; bus.ls_adr = 32'h40;
    bus.if_req = 1'b1; bus.ls_req = 1'b1;
    for (int c = 1; c <= 4 * P; c++) begin
      logic [1:0] e;
      @(posedge clk); @(negedge clk);
      e = 2'b00;
      if (c % P == LAT + 1) e = ((c / P) % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_pattern", 32'({bus.if_rdy, bus.ls_rdy}), 32'(e));
      if (e[0]) check("rr_ls_data", bus.ls_rdata, ref_load(3'b010, 32'h40));
      if (e[1]) check("rr_if_data", bus.if_data, ref_fetch(32'h48));
      if (c == 4 * P - 1) begin
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
      end
    end
    last_ls = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-wide, single-port memory between the instruction-fetch requester (IF) and the load/store unit (LS).
- Each requester gets a request/ready handshake.
- LS accesses get byte-lane steering, sign/zero extension and alignment checks based on RISC-V fun3.
- Sits between the fetch controller, the execute stage and the memory array. Its busy output drives the fetch stall input.

Parameters:
- MEM_LAT, 1: cycles from address presentation to valid mem_out (≥1).
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request; held with if_adr until if_rdy.
- if_adr  in  32  fetch byte address; bits [1:0] ignored.
- if_rdy  out  1  one-cycle pulse; if_data valid in the same cycle.
- if_data  out  32  fetched instruction word.
- ls_req  in  1  load/store request; held with its operands until ls_rdy.
- ls_we  in  1  1 = store, 0 = load.
- ls_fun3  in  3  access size/sign (RISC-V fun3).
- ls_adr  in  32  byte address.
- ls_wdata  in  32  store data, right-aligned.
- ls_rdy  out  1  one-cycle completion pulse.
- ls_rdata  out  32  extended load data; 0 for stores and errors.
- ls_err  out  1  with ls_rdy: misaligned access or illegal fun3.
- mem_adr  out  32  word address {adr[31:2],2'b00}.
- mem_load  out  1  memory write strobe.
- mem_be  out  4  byte enables for the write.
- mem_in  out  32  lane-replicated write data.
- mem_out  in  32  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset value of every output is 0.
- Reset asserted mid-transaction:
  - aborts the transaction immediately (asynchronously), with no rdy pulse;
  - forces state to IDLE and the round-robin pointer to favour LS.
- States: IDLE, IF_WAIT, LS_WAIT, RESP. Transitions:
  - IDLE: if exactly one req is high, grant it. If both are high, grant the side not granted last (round-robin; after reset LS wins). Go to IF_WAIT or LS_WAIT, load the counter with MEM_LAT and latch the operands. If neither req is high, stay in IDLE.
  - *_WAIT: drive mem_adr from the latched address. Decrement the counter each cycle. When the counter reaches 1, capture mem_out and go to RESP.
  - RESP: pulse if_rdy or ls_rdy with its data. Go to IDLE; that rdy cycle performs no arbitration.
- Timing: req sampled high at edge 0 → WAIT for cycles 1..MEM_LAT → rdy high in cycle MEM_LAT+1.
  - The requester drops or changes req from cycle MEM_LAT+2, so back-to-back grants are MEM_LAT+2 cycles apart.
- Stores:
  - mem_load=1 only in the first LS_WAIT cycle; mem_be and mem_in are valid in that cycle and 0 otherwise.
  - Store latency is identical to load latency.
- fun3 decoding:
  - 000 LB/SB: be = 1<<adr[1:0]; mem_in = {4{wdata[7:0]}}.
  - 001 LH/SH: be = adr[1] ? 1100 : 0011; mem_in = {2{wdata[15:0]}}.
  - 010 LW/SW: be = 1111.
  - 100 LBU and 101 LHU: loads only.
- Loads: select the lane by adr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Errors:
  - Conditions: halfword access with adr[0]=1; word access with adr[1:0]!=0; fun3 ∈ {011,110,111}; store with fun3 ∈ {100,101}.
  - Handling: no memory access (mem_load stays 0). Go IDLE→RESP directly: ls_rdy=ls_err=1 and ls_rdata=0 in the cycle after the grant.
  - An error grant still updates the round-robin pointer.
- Fetch never errors; if_adr[1:0] are dropped.
- An input req that falls before its rdy is a protocol violation: the latched transaction still completes and its rdy still pulses.
- busy is combinational from the state register; it is low only in IDLE.
- Outputs:
  - if_data and ls_rdata are registered and are 0 outside their rdy cycle.
  - mem_adr is 0 in IDLE and RESP.

Test Plan:
- MEM_LAT=2, IF only, if_adr=0x0000_0006, mem[0x4]=0x0000_0013 → mem_adr=0x4 in cycles 1-2; if_rdy and if_data=0x13 in cycle 3; busy high in cycles 1-3.
- LB at ls_adr=0x103 with mem[0x100]=0x80FF_1234 → ls_rdata=0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x102 → 0x0000_80FF.
- SH at ls_adr=0x202, wdata=0x1234_ABCD → a single cycle with mem_load=1, mem_be=1100, mem_in=0xABCD_ABCD, mem_adr=0x200; ls_rdy 2 cycles later.
- SW at 0x301 → ls_err=1 and ls_rdy in the cycle after the grant; mem_load never asserts. fun3=011 load → the same response.
- if_req and ls_req held continuously from reset → grant order LS, IF, LS, IF; each grant MEM_LAT+2 cycles apart; no rdy cycle overlaps another grant.
- rst pulsed in the second LS_WAIT cycle of a store → all outputs 0 immediately; no ls_rdy; the next simultaneous request after reset grants LS first.
